// File: rtl/icache_axi_pkg.sv
// Shared definitions for the icache line-fill AXI4 read master.
//   - One-hot FSM state encodings (IDLE, AR, R, RESP)
//   - AXI4 field constants used on the AR channel and for RRESP decoding
//   - Default line size and a helper that line-aligns a fill address
package icache_axi_pkg;

    localparam int DEFAULT_LINE_WORDS = 8;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_AR   = 4'b0010;
    localparam logic [3:0] ST_R    = 4'b0100;
    localparam logic [3:0] ST_RESP = 4'b1000;

    // Clears the byte-offset-within-line bits of a fill address.
    function automatic logic [31:0] line_align(input logic [31:0] addr, input int line_words);
        logic [31:0] line_bytes;
        line_bytes = 32'(line_words * 4);
        return addr & ~(line_bytes - 32'd1);
    endfunction

endpackage

// File: rtl/icache_axi_line_fetch_line_assembler.sv
// Collects the beats of one read burst into a full cache line.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (clears counter and line)
//   clear       - restart at word 0 for a new burst (line contents are kept)
//   beat_we     - an accepted R beat: store rdata at the current word, advance
//   rdata       - 32-bit beat data
//   line        - assembled line, word i at [32i+31:32i]
//   last_beat   - the counter points at the final word of the line
module line_assembler #(
    parameter int LINE_WORDS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       beat_we,
    input  logic [31:0]                rdata,
    output logic [LINE_WORDS*32-1:0]   line,
    output logic                       last_beat
);

    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(LINE_WORDS - 1);

    logic [CW-1:0]                 cnt;
    logic [LINE_WORDS-1:0][31:0]   words;

    // The counter wraps to zero on the final beat, which is also the beat
    // that takes the FSM out of R, so no explicit terminal handling is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            words <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (beat_we) begin
            words[cnt] <= rdata;
            cnt        <= cnt + CW'(1);
        end
    end

    assign line      = words;
    assign last_beat = (cnt == LAST_IDX);

endmodule

// File: rtl/icache_axi_line_fetch.sv
// Icache miss-path line fetcher: turns one line-fill request into a single
// AXI4 INCR read burst and returns the assembled line with a one-cycle pulse.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   icache_mem_read_request/_addr   - fill request and address (offset bits ignored)
//   mem_ready_to_read               - idle, a request would be accepted
//   mem_read_addr_ok                - request accepted this cycle
//   mem_return_en/_data/_err        - line return pulse, line data, error status
//   arid..arvalid, arready          - AXI read address channel
//   rid..rvalid, rready             - AXI read data channel
module icache_axi_line_fetch
    import icache_axi_pkg::*;
#(
    parameter int         LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       icache_mem_read_request,
    input  logic [31:0]                icache_mem_read_addr,
    output logic                       mem_ready_to_read,
    output logic                       mem_read_addr_ok,
    output logic                       mem_return_en,
    output logic [LINE_WORDS*32-1:0]   mem_return_data,
    output logic                       mem_return_err,
    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready
);

    logic [3:0]  state;
    logic [3:0]  state_next;
    logic [31:0] ar_addr;
    logic        err_flag;
    logic        accept;
    logic        beat_fire;
    logic        last_beat;
    logic        unused_rid;

    // Single ID, in-order responses: rid carries no information here.
    assign unused_rid = ^rid;

    assign accept    = (state == ST_IDLE) && icache_mem_read_request;
    assign beat_fire = (state == ST_R) && rvalid;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (icache_mem_read_request) state_next = ST_AR;
            ST_AR:   if (arready)                 state_next = ST_R;
            // Completion follows the beat count; a misplaced rlast only flags an error.
            ST_R:    if (rvalid && last_beat)     state_next = ST_RESP;
            ST_RESP:                              state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ar_addr  <= '0;
            err_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                ar_addr  <= line_align(icache_mem_read_addr, LINE_WORDS);
                err_flag <= 1'b0;
            end else if (beat_fire && ((rresp != AXI_RESP_OKAY) || (rlast != last_beat))) begin
                err_flag <= 1'b1;
            end
        end
    end

    line_assembler #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .beat_we   (beat_fire),
        .rdata     (rdata),
        .line      (mem_return_data),
        .last_beat (last_beat)
    );

    assign mem_ready_to_read = (state == ST_IDLE);
    assign mem_read_addr_ok  = accept;
    assign mem_return_en     = (state == ST_RESP);
    assign mem_return_err    = (state == ST_RESP) && err_flag;

    // AR fields come from registers/constants, so they stay stable while arvalid waits.
    assign arvalid = (state == ST_AR);
    assign arid    = AXI_ID;
    assign araddr  = ar_addr;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign rready  = (state == ST_R);

endmodule

// File: tb/tb_icache_axi_line_fetch.sv
// Directed testbench for icache_axi_line_fetch at the default 8-word line.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge of the same cycle.
module tb_icache_axi_line_fetch;

    localparam int LW    = 8;
    localparam int LBITS = LW * 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic [31:0]       req_addr;
    logic              mem_ready_to_read;
    logic              mem_read_addr_ok;
    logic              mem_return_en;
    logic [LBITS-1:0]  mem_return_data;
    logic              mem_return_err;
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    icache_axi_line_fetch #(
        .LINE_WORDS (LW),
        .AXI_ID     (4'd0)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .icache_mem_read_request (req),
        .icache_mem_read_addr    (req_addr),
        .mem_ready_to_read       (mem_ready_to_read),
        .mem_read_addr_ok        (mem_read_addr_ok),
        .mem_return_en           (mem_return_en),
        .mem_return_data         (mem_return_data),
        .mem_return_err          (mem_return_err),
        .arid                    (arid),
        .araddr                  (araddr),
        .arlen                   (arlen),
        .arsize                  (arsize),
        .arburst                 (arburst),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .rid                     (rid),
        .rdata                   (rdata),
        .rresp                   (rresp),
        .rlast                   (rlast),
        .rvalid                  (rvalid),
        .rready                  (rready)
    );

    function automatic logic [LBITS-1:0] mk_line(input logic [31:0] base);
        logic [LBITS-1:0] r;
        r = '0;
        for (int i = 0; i < LW; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 1'b0; req_addr = '0; arready = 1'b0; rid = '0;
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    endtask

    // Drives one complete fill with arready=1 and back-to-back beats, and
    // reports what was observed; cycle 0 is the request cycle.
    task automatic run_line(input logic [31:0] addr, input logic [31:0] base,
                            input int bad_beat, input int last_idx,
                            output logic ok0, output logic [31:0] ar1,
                            output int lat, output int pulses,
                            output logic [LBITS-1:0] line, output logic err);
        ok0 = 1'b0; ar1 = 32'hFFFF_FFFF; lat = -1; pulses = 0; line = '0; err = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            req      = (c == 0);
            req_addr = addr;
            arready  = 1'b1;
            rvalid   = (c >= 2) && (c <= 9);
            rdata    = base + 32'(c - 2);
            rresp    = (rvalid && (c - 2 == bad_beat)) ? 2'b10 : 2'b00;
            rlast    = rvalid && (c - 2 == last_idx);
            @(negedge clk);
            if (c == 0) ok0 = mem_read_addr_ok;
            if (c == 1 && arvalid) ar1 = araddr;
            if (mem_return_en) begin
                pulses++;
                if (lat < 0) begin
                    lat  = c;
                    line = mem_return_data;
                    err  = mem_return_err;
                end
            end
        end
        idle_inputs();
    endtask

    // Supplies beats until the return pulse shows up (bounded).
    task automatic drain_burst();
        for (int k = 0; k < 30; k++) begin
            step();
            arready = 1'b1; rvalid = 1'b1; rdata = 32'(k); rresp = 2'b00; rlast = 1'b0;
            @(negedge clk);
            if (mem_return_en) break;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        total++; if (mem_ready_to_read !== 1'b1) $display("FAIL rst_ready: got %b exp 1", mem_ready_to_read); else passed++;
        total++; if (arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b exp 0", arvalid); else passed++;
        total++; if (rready !== 1'b0) $display("FAIL rst_rready: got %b exp 0", rready); else passed++;
        total++; if ({mem_return_en, mem_return_err, mem_read_addr_ok} !== 3'b000)
            $display("FAIL rst_en_err_ok: got %b exp 000", {mem_return_en, mem_return_err, mem_read_addr_ok}); else passed++;
        total++; if (mem_return_data !== '0) $display("FAIL rst_data: got %h exp 0", mem_return_data); else passed++;
        total++; if (araddr !== 32'h0) $display("FAIL rst_araddr: got %h exp 0", araddr); else passed++;
    endtask

    task automatic test_basic();
        logic [LBITS-1:0] exp_line;
        exp_line = mk_line(32'hA0);
        step();
        req = 1'b1; req_addr = 32'h1C00_0034; arready = 1'b1;
        @(negedge clk);
        total++; if ({mem_read_addr_ok, mem_ready_to_read, arvalid} !== 3'b110)
            $display("FAIL basic_accept: got %b exp 110", {mem_read_addr_ok, mem_ready_to_read, arvalid}); else passed++;
        step();
        req = 1'b0;
        @(negedge clk);
        total++; if (arvalid !== 1'b1) $display("FAIL basic_arvalid: got %b exp 1", arvalid); else passed++;
        total++; if (araddr !== 32'h1C00_0020) $display("FAIL basic_araddr: got %h exp 1c000020", araddr); else passed++;
        total++; if ({arlen, arsize, arburst, arid} !== {8'd7, 3'd2, 2'd1, 4'd0})
            $display("FAIL basic_arfields: got len=%0d size=%0d burst=%0d id=%0d exp 7 2 1 0", arlen, arsize, arburst, arid); else passed++;
        total++; if ({mem_read_addr_ok, mem_ready_to_read} !== 2'b00)
            $display("FAIL basic_busy: got %b exp 00", {mem_read_addr_ok, mem_ready_to_read}); else passed++;
        for (int i = 0; i < LW; i++) begin
            step();
            rvalid = 1'b1; rdata = 32'hA0 + 32'(i); rresp = 2'b00; rlast = (i == LW - 1);
            @(negedge clk);
            total++; if ({rready, mem_return_en} !== 2'b10)
                $display("FAIL basic_beat%0d: got rready/en %b exp 10", i, {rready, mem_return_en}); else passed++;
        end
        step();
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        total++; if ({mem_return_en, mem_return_err} !== 2'b10)
            $display("FAIL basic_ret: got en/err %b exp 10 at N+10", {mem_return_en, mem_return_err}); else passed++;
        total++; if (mem_return_data !== exp_line) $display("FAIL basic_data: got %h exp %h", mem_return_data, exp_line); else passed++;
        step();
        @(negedge clk);
        total++; if ({mem_return_en, mem_ready_to_read} !== 2'b01)
            $display("FAIL basic_after: got en/ready %b exp 01", {mem_return_en, mem_ready_to_read}); else passed++;
        total++; if (mem_return_data !== exp_line) $display("FAIL basic_hold: got %h exp %h", mem_return_data, exp_line); else passed++;
    endtask

    task automatic test_stalls();
        logic [LBITS-1:0] exp_line;
        logic [LBITS-1:0] got;
        int pulses;
        exp_line = mk_line(32'hB0);
        got = '0;
        pulses = 0;
        step();
        req = 1'b1; req_addr = 32'h0000_1044; arready = 1'b0;
        @(negedge clk);
        total++; if (mem_read_addr_ok !== 1'b1) $display("FAIL stall_accept: got %b exp 1", mem_read_addr_ok); else passed++;
        for (int k = 0; k < 5; k++) begin
            step();
            req = 1'b0; arready = 1'b0;
            @(negedge clk);
            total++; if ({arvalid, araddr, arlen} !== {1'b1, 32'h0000_1040, 8'd7})
                $display("FAIL stall_ar_wait%0d: got v=%b a=%h l=%0d exp 1 00001040 7", k, arvalid, araddr, arlen); else passed++;
        end
        step();
        arready = 1'b1;
        @(negedge clk);
        total++; if ({arvalid, araddr} !== {1'b1, 32'h0000_1040})
            $display("FAIL stall_ar_hs: got v=%b a=%h exp 1 00001040", arvalid, araddr); else passed++;
        for (int i = 0; i < LW; i++) begin
            step();
            arready = 1'b0; rvalid = 1'b1; rdata = 32'hB0 + 32'(i); rlast = (i == LW - 1);
            @(negedge clk);
            if (mem_return_en) begin pulses++; got = mem_return_data; end
            if (i < LW - 1) begin
                step();
                rvalid = 1'b0; rlast = 1'b0; rdata = 32'hDEAD_BEEF;
                @(negedge clk);
                if (mem_return_en) begin pulses++; got = mem_return_data; end
            end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            rvalid = 1'b0; rlast = 1'b0;
            @(negedge clk);
            if (mem_return_en) begin pulses++; got = mem_return_data; end
        end
        total++; if (pulses !== 1) $display("FAIL stall_pulses: got %0d exp 1", pulses); else passed++;
        total++; if (got !== exp_line) $display("FAIL stall_data: got %h exp %h", got, exp_line); else passed++;
    endtask

    task automatic test_errors();
        logic ok0; logic [31:0] ar1; int lat; int pulses; logic [LBITS-1:0] line; logic err;
        run_line(32'h4000_0000, 32'hD0, 3, 7, ok0, ar1, lat, pulses, line, err);
        total++; if ({lat, pulses} !== {32'd10, 32'd1}) $display("FAIL err_resp_timing: got lat=%0d pulses=%0d exp 10 1", lat, pulses); else passed++;
        total++; if (err !== 1'b1) $display("FAIL err_resp_flag: got %b exp 1", err); else passed++;
        total++; if (line !== mk_line(32'hD0)) $display("FAIL err_resp_data: got %h exp %h", line, mk_line(32'hD0)); else passed++;
        run_line(32'h4000_0100, 32'hE0, -1, 5, ok0, ar1, lat, pulses, line, err);
        total++; if ({lat, pulses} !== {32'd10, 32'd1}) $display("FAIL err_rlast_timing: got lat=%0d pulses=%0d exp 10 1", lat, pulses); else passed++;
        total++; if (err !== 1'b1) $display("FAIL err_rlast_flag: got %b exp 1", err); else passed++;
        total++; if (line !== mk_line(32'hE0)) $display("FAIL err_rlast_data: got %h exp %h", line, mk_line(32'hE0)); else passed++;
    endtask

    task automatic test_held_request();
        int ok_extra; int ar_cnt; int en_c;
        ok_extra = 0; ar_cnt = 0; en_c = -1;
        step();
        req = 1'b1; req_addr = 32'h5000_0060; arready = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        total++; if (mem_read_addr_ok !== 1'b1) $display("FAIL held_accept: got %b exp 1", mem_read_addr_ok); else passed++;
        for (int c = 1; c <= 10; c++) begin
            step();
            req = 1'b1;
            rvalid = (c >= 2) && (c <= 9); rdata = 32'hF0 + 32'(c - 2); rlast = (c == 9);
            @(negedge clk);
            if (mem_read_addr_ok) ok_extra++;
            if (arvalid) ar_cnt++;
            if (mem_return_en && en_c < 0) en_c = c;
        end
        total++; if (ok_extra !== 0) $display("FAIL held_ok_busy: got %0d exp 0", ok_extra); else passed++;
        total++; if (ar_cnt !== 1) $display("FAIL held_ar_count: got %0d exp 1", ar_cnt); else passed++;
        total++; if (en_c !== 10) $display("FAIL held_ret_cycle: got %0d exp 10", en_c); else passed++;
        step();
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge clk);
        total++; if ({mem_read_addr_ok, arvalid} !== 2'b10)
            $display("FAIL held_reaccept: got ok/arvalid %b exp 10", {mem_read_addr_ok, arvalid}); else passed++;
        step();
        req = 1'b0;
        @(negedge clk);
        total++; if (arvalid !== 1'b1) $display("FAIL held_second_ar: got %b exp 1", arvalid); else passed++;
        drain_burst();
    endtask

    task automatic test_reset_mid_burst();
        logic ok0; logic [31:0] ar1; int lat; int pulses; logic [LBITS-1:0] line; logic err;
        int seen;
        seen = 0;
        step();
        req = 1'b1; req_addr = 32'h2000_0000; arready = 1'b1; rvalid = 1'b0;
        step();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            rvalid = 1'b1; rdata = 32'h11 + 32'(i); rlast = 1'b0;
        end
        step();
        rvalid = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        total++; if ({arvalid, rready, mem_ready_to_read} !== 3'b001)
            $display("FAIL mrst_ctrl: got arvalid/rready/ready %b exp 001", {arvalid, rready, mem_ready_to_read}); else passed++;
        total++; if (mem_return_data !== '0) $display("FAIL mrst_data: got %h exp 0", mem_return_data); else passed++;
        total++; if ({mem_return_en, mem_return_err} !== 2'b00)
            $display("FAIL mrst_en: got en/err %b exp 00", {mem_return_en, mem_return_err}); else passed++;
        for (int k = 0; k < 12; k++) begin
            step();
            @(negedge clk);
            if (mem_return_en) seen++;
        end
        total++; if (seen !== 0) $display("FAIL mrst_no_ret: got %0d pulses exp 0", seen); else passed++;
        run_line(32'h3000_0044, 32'hC0, -1, 7, ok0, ar1, lat, pulses, line, err);
        total++; if ({ok0, ar1} !== {1'b1, 32'h3000_0040})
            $display("FAIL mrst_new_ar: got ok=%b araddr=%h exp 1 30000040", ok0, ar1); else passed++;
        total++; if ({lat, pulses} !== {32'd10, 32'd1}) $display("FAIL mrst_new_timing: got lat=%0d pulses=%0d exp 10 1", lat, pulses); else passed++;
        total++; if ({err, line} !== {1'b0, mk_line(32'hC0)})
            $display("FAIL mrst_new_line: got err=%b %h exp 0 %h", err, line, mk_line(32'hC0)); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [LBITS-1:0] l1;
        logic [LBITS-1:0] l2;
        logic [LBITS-1:0] got;
        int lat;
        l1 = mk_line(32'h100);
        l2 = mk_line(32'h200);
        got = '0;
        lat = -1;
        step();
        req = 1'b1; req_addr = 32'h0000_0000; arready = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        total++; if (mem_read_addr_ok !== 1'b1) $display("FAIL b2b_accept1: got %b exp 1", mem_read_addr_ok); else passed++;
        for (int c = 1; c <= 9; c++) begin
            step();
            req = 1'b0;
            rvalid = (c >= 2); rdata = 32'h100 + 32'(c - 2); rlast = (c == 9);
        end
        step();
        rvalid = 1'b0; rlast = 1'b0; req = 1'b1; req_addr = 32'h0000_0020;
        @(negedge clk);
        total++; if ({mem_return_en, mem_read_addr_ok} !== 2'b10)
            $display("FAIL b2b_resp1: got en/ok %b exp 10", {mem_return_en, mem_read_addr_ok}); else passed++;
        total++; if (mem_return_data !== l1) $display("FAIL b2b_line1: got %h exp %h", mem_return_data, l1); else passed++;
        step();
        @(negedge clk);
        total++; if ({mem_read_addr_ok, mem_return_en} !== 2'b10)
            $display("FAIL b2b_accept2: got ok/en %b exp 10", {mem_read_addr_ok, mem_return_en}); else passed++;
        total++; if (mem_return_data !== l1) $display("FAIL b2b_hold_acc: got %h exp %h", mem_return_data, l1); else passed++;
        step();
        req = 1'b0;
        @(negedge clk);
        total++; if ({arvalid, araddr} !== {1'b1, 32'h0000_0020})
            $display("FAIL b2b_ar2: got v=%b a=%h exp 1 00000020", arvalid, araddr); else passed++;
        total++; if (mem_return_data !== l1) $display("FAIL b2b_hold_ar: got %h exp %h", mem_return_data, l1); else passed++;
        for (int c = 13; c <= 20; c++) begin
            step();
            rvalid = 1'b1; rdata = 32'h200 + 32'(c - 13); rlast = (c == 20);
            @(negedge clk);
            if (c == 13) begin
                total++; if (mem_return_data !== l1) $display("FAIL b2b_hold_beat0: got %h exp %h", mem_return_data, l1); else passed++;
            end
        end
        for (int c = 21; c <= 24; c++) begin
            step();
            rvalid = 1'b0; rlast = 1'b0;
            @(negedge clk);
            if (mem_return_en && lat < 0) begin lat = c; got = mem_return_data; end
        end
        total++; if (lat !== 21) $display("FAIL b2b_ret2_cycle: got %0d exp 21", lat); else passed++;
        total++; if (got !== l2) $display("FAIL b2b_line2: got %h exp %h", got, l2); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_stalls();
        test_errors();
        test_held_request();
        test_reset_mid_burst();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
